// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder initiator (serial_adder_driver).
package serial_adder_pkg;

  localparam int SERIAL_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Loadable right-shift register: LSB is the serial output end, serial data enters at the MSB.
module serial_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  input  logic         ser_in,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (shift) begin
      r_q <= {ser_in, r_q[W-1:1]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/serial_adder_driver.sv
// Initiator for an external bit-serial adder: clear carry, stream operands LSB-first, collect W+1 sum bits.
// Optional self-check against a parallel reference sum: define SERIAL_ADDER_DRIVER_CHECK_EN.
module serial_adder_driver
  import serial_adder_pkg::*;
#(
  parameter int W = SERIAL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         ser_rst,
  output logic         ser_a,
  output logic         ser_b,
  input  logic         ser_sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_sum
`ifdef SERIAL_ADDER_DRIVER_CHECK_EN
  ,
  output logic         mismatch
`endif
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both high.
  // in_ready depends only on state; out_valid/out_sum hold steady until out_ready.
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(W);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_shift;
  logic          w_last;
  logic [W-1:0]  w_a_q;
  logic [W-1:0]  w_b_q;
  logic [W:0]    w_sum_q;
  logic          w_unused_bits;

  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid & in_ready;
  assign w_shift  = (r_state == SHIFT);
  assign w_last   = w_shift && (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = CLEAR;
      CLEAR:   w_next_state = SHIFT;
      SHIFT:   if (w_last) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  serial_shift_reg #(.W(W)) u_a_sh (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_accept),
    .shift  (w_shift),
    .d      (in_a),
    .ser_in (1'b0),
    .q      (w_a_q)
  );

  serial_shift_reg #(.W(W)) u_b_sh (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_accept),
    .shift  (w_shift),
    .d      (in_b),
    .ser_in (1'b0),
    .q      (w_b_q)
  );

  // Zero fill means the extra (W+1)th bit presents a=b=0, so ser_sum carries the carry-out.
  serial_shift_reg #(.W(W + 1)) u_sum_sh (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_accept),
    .shift  (w_shift),
    .d      ({(W + 1){1'b0}}),
    .ser_in (ser_sum),
    .q      (w_sum_q)
  );

  assign w_unused_bits = ^{w_a_q[W-1:1], w_b_q[W-1:1]};

  // Carry clear is held during driver reset as well, so the adder never starts with stale carry.
  assign ser_rst   = ~rst_n | (r_state == CLEAR);
  assign ser_a     = w_shift & w_a_q[0];
  assign ser_b     = w_shift & w_b_q[0];
  assign out_valid = (r_state == DONE);
  assign out_sum   = w_sum_q;

`ifdef SERIAL_ADDER_DRIVER_CHECK_EN
  logic [W:0] r_expected;
  logic       r_mismatch;
  logic [W:0] w_sum_next;

  assign w_sum_next = {ser_sum, w_sum_q[W:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_expected <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_accept) r_expected <= {1'b0, in_a} + {1'b0, in_b};
      if (w_last && (w_sum_next != r_expected)) r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_serial_adder_driver.sv
// Bench for serial_adder_driver (W=8) with a behavioural serial adder attached.
module tb_serial_adder_driver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         ser_rst;
  logic         ser_a;
  logic         ser_b;
  logic         ser_sum;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;
`ifdef SERIAL_ADDER_DRIVER_CHECK_EN
  logic         mismatch;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder_driver #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .ser_rst   (ser_rst),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_sum   (ser_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
`ifdef SERIAL_ADDER_DRIVER_CHECK_EN
    ,
    .mismatch  (mismatch)
`endif
  );

  // Behavioural bit-serial adder: combinational sum, registered carry with synchronous clear.
  logic r_carry;
  always_ff @(posedge clk) begin
    if (ser_rst) r_carry <= 1'b0;
    else         r_carry <= (ser_a & ser_b) | (ser_a & r_carry) | (ser_b & r_carry);
  end
  assign ser_sum = ser_a ^ ser_b ^ r_carry;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push at input handshake, pop and compare at output handshake.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: got 0x%0h with no expected entry", out_sum);
      end else begin
        check("sb_order", {23'd0, out_sum}, {23'd0, exp_q.pop_front()});
      end
      n_pop++;
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] exp,
                       input string name);
    int guard;
    int lat;
    @(posedge clk);
    #1;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    guard    = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({name, "_ser_rst_hi"}, {31'd0, ser_rst}, 32'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) check({name, "_ser_rst_lo"}, {31'd0, ser_rst}, 32'd0);
    end
    check({name, "_latency"}, lat, 32'd10);
    check({name, "_sum"}, {23'd0, out_sum}, {23'd0, exp});
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int base;
    int cguard;

    vecs[0] = '{8'h25, 8'h1A, 9'h03F};
    vecs[1] = '{8'hFF, 8'h01, 9'h100};
    vecs[2] = '{8'hFF, 8'hFF, 9'h1FE};
    vecs[3] = '{8'h00, 8'h00, 9'h000};
    vecs[4] = '{8'h80, 8'h80, 9'h100};
    vecs[5] = '{8'hAA, 8'h55, 9'h0FF};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {23'd0, out_sum}, 32'd0);
    check("rst_ser_rst", {31'd0, ser_rst}, 32'd1);
    check("rst_ser_ab", {30'd0, ser_a, ser_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ser_rst", {31'd0, ser_rst}, 32'd0);

    // Table of directed sums, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while in_valid pulses are ignored.
    @(posedge clk);
    #1 out_ready = 1'b0;
    do_op(8'hFF, 8'hFF, 9'h1FE, "bp");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      in_valid = k[0];
      in_a     = W'($urandom_range(0, 255));
      in_b     = W'($urandom_range(0, 255));
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_sum", {23'd0, out_sum}, 32'h1FE);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_released", {31'd0, out_valid}, 32'd0);

    // Reset mid-SHIFT at cnt=4: operation abandoned.
    @(posedge clk);
    #1;
    in_a     = 8'h55;
    in_b     = 8'h33;
    in_valid = 1'b1;
    @(negedge clk);
    check("rm_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rm_ser_rst", {31'd0, ser_rst}, 32'd1);
    @(posedge clk);
    #1;
    check("rm_in_ready", {31'd0, in_ready}, 32'd1);
    check("rm_out_valid", {31'd0, out_valid}, 32'd0);
    check("rm_ser_rst_held", {31'd0, ser_rst}, 32'd1);
    rst_n = 1'b1;
    exp_q.delete();
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("rm_no_pulse", pulses, 32'd0);
    do_op(8'h01, 8'h01, 9'h002, "rm_next");

    // Random traffic with gaps on both sides.
    base = n_pop + 1;
    @(posedge clk);
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int gap;
          int g;
          gap = $urandom_range(0, 3);
          repeat (gap) @(posedge clk);
          #1;
          in_a     = W'($urandom_range(0, 255));
          in_b     = W'($urandom_range(0, 255));
          in_valid = 1'b1;
          g = 0;
          @(negedge clk);
          while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
          end
          if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL rnd_accept_timeout: op %0d not accepted", i);
            break;
          end
          @(posedge clk);
          #1 in_valid = 1'b0;
        end
      end
      begin
        cguard = 0;
        while (n_pop < base + 1000 && cguard < 40000) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
          cguard++;
        end
        #1 out_ready = 1'b1;
      end
    join
    check("rnd_count", n_pop - base, 32'd1000);
    check("rnd_queue_empty", exp_q.size(), 32'd0);
`ifdef SERIAL_ADDER_DRIVER_CHECK_EN
    check("mismatch_clear", {31'd0, mismatch}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
